// File: rtl/program_loader.sv
// program_loader: writer side of the program memory.
// Packs a little-endian byte stream (valid/ready) into 32-bit words, writes
// them from word address 0 upward, and holds the CPU in reset until a program
// ending with END_WORD has been written.
// Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
// byte_ready depends only on state, never on byte_valid.
// Optional build macro PROGRAM_LOADER_CHECKSUM_EN: after the terminator a
// 4-byte little-endian checksum (sum mod 2^32 of all written words) follows
// and must match before the CPU is released.
module program_loader #(
  parameter int          PROGRAM_MEMORY_SIZE_WORDS = 100,
  parameter int          ADDR_WIDTH                = 7,
  parameter logic [31:0] END_WORD                  = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PROGRAM_MEMORY_SIZE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t     state, state_next;
  logic [1:0] byte_idx;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [31:0] acc;
  logic [23:0] chk_lo;
`endif

  // Ready is a pure state decode so the sender never sees it depend on valid.
  assign byte_ready = (state == S_RECV) || (state == S_CHECK);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode; start only matters in the idle-like states.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_RECV;
      S_RECV: if (byte_valid && byte_idx == 2'd3) state_next = S_WRITE;
      S_WRITE: begin
        if (mem_wdata == END_WORD) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_next = S_CHECK;
`else
          state_next = S_DONE;
`endif
        end else if (mem_addr == LAST_ADDR) begin
          // Memory full without a terminator; never write past the end.
          state_next = S_ERROR;
        end else begin
          state_next = S_RECV;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK: if (byte_valid && byte_idx == 2'd3)
                 state_next = (acc == {byte_data, chk_lo}) ? S_DONE : S_ERROR;
`endif
      S_DONE, S_ERROR: if (start) state_next = S_RECV;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and registered status outputs, all derived from the next state
  // so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx   <= 2'd0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      acc        <= '0;
      chk_lo     <= '0;
`endif
    end else begin
      mem_we    <= (state_next == S_WRITE);
      busy      <= (state_next == S_RECV) || (state_next == S_WRITE) ||
                   (state_next == S_CHECK);
      done      <= (state_next == S_DONE);
      error     <= (state_next == S_ERROR);
      cpu_reset <= (state_next != S_DONE);
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            mem_addr   <= '0;
            word_count <= '0;
            byte_idx   <= 2'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            acc        <= '0;
`endif
          end
        end
        S_RECV: begin
          if (byte_valid) begin
            mem_wdata[{byte_idx, 3'b000} +: 8] <= byte_data;
            byte_idx <= byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          word_count <= word_count + (ADDR_WIDTH+1)'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          acc <= acc + mem_wdata;
`endif
          if (state_next == S_RECV) mem_addr <= mem_addr + ADDR_WIDTH'(1);
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (byte_valid) begin
            case (byte_idx)
              2'd0:    chk_lo[7:0]   <= byte_data;
              2'd1:    chk_lo[15:8]  <= byte_data;
              2'd2:    chk_lo[23:16] <= byte_data;
              default: chk_lo        <= chk_lo;
            endcase
            byte_idx <= byte_idx + 2'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed loads from the test plan plus randomized
// programs, with a write scoreboard fed by a queue-based program model.
module tb_program_loader;

  localparam int          SIZE   = 4;
  localparam int          AW     = 3;
  localparam logic [31:0] END_W  = 32'h00000013;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit          CHK_EN = 1'b1;
`else
  localparam bit          CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_reset, busy, done, error;
  logic [AW:0]   word_count;

  int checks = 0;
  int passes = 0;
  int write_cnt = 0;
  bit chk_done_next = 1'b0;

  logic [31:0]   exp_q[$];
  logic [AW-1:0] exp_addr_q[$];

  program_loader #(
    .PROGRAM_MEMORY_SIZE_WORDS(SIZE),
    .ADDR_WIDTH(AW),
    .END_WORD(END_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every write must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (chk_done_next) begin
      check("done_cycle_after_end", {30'd0, cpu_reset, done}, 32'd1);
      chk_done_next = 1'b0;
    end
    if (!reset && mem_we) begin
      write_cnt++;
      check("write_addr_in_range", {31'd0, (int'(mem_addr) < SIZE)}, 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {29'd0, mem_addr}, 32'hFFFFFFFF);
      end else begin
        check("write_addr", {29'd0, mem_addr}, {29'd0, exp_addr_q.pop_front()});
        check("write_data", mem_wdata, exp_q.pop_front());
      end
`ifndef PROGRAM_LOADER_CHECKSUM_EN
      if (mem_wdata == END_W) chk_done_next = 1'b1;
`endif
    end
  end

  // Driver: present one byte from a negedge, hold until accepted, then idle
  // for 'gap' cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) check("byte_accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = $urandom;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Reference model: words are stored in order until the terminator is
  // stored or memory is full.
  task automatic model(input logic [31:0] w[$], output int nwr, output bit term,
                       output logic [31:0] sum);
    nwr = 0; term = 1'b0; sum = 32'd0;
    foreach (w[i]) begin
      if (nwr == SIZE) break;
      nwr++;
      sum += w[i];
      if (w[i] == END_W) begin
        term = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_load(input logic [31:0] w[$], input int gap, input bit bad_sum,
                          input bit mid_start);
    int nwr, n;
    bit term, exp_ok;
    logic [31:0] sum;
    model(w, nwr, term, sum);
    exp_ok = term && !(CHK_EN && bad_sum);
    for (int i = 0; i < nwr; i++) begin
      exp_q.push_back(w[i]);
      exp_addr_q.push_back(AW'(i));
    end
    write_cnt = 0;
    pulse_start();
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_flags", {29'd0, cpu_reset, done, error}, 32'b100);
    check("start_word_count", {28'd0, word_count}, 32'd0);
    for (int i = 0; i < nwr; i++) begin
      send_word(w[i], gap);
      if (mid_start && i == 0) pulse_start();
    end
    if (CHK_EN && term) send_word(bad_sum ? sum + 32'd1 : sum, gap);
    n = 0;
    while (!(done || error) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("end_done", {31'd0, done}, {31'd0, exp_ok});
    check("end_error", {31'd0, error}, {31'd0, !exp_ok});
    check("end_cpu_reset", {31'd0, cpu_reset}, {31'd0, !exp_ok});
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_word_count", {28'd0, word_count}, nwr);
    check("write_count", write_cnt, nwr);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_addr"}, {29'd0, mem_addr}, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_flags"}, {28'd0, cpu_reset, busy, done, error}, 32'b1000);
    check({tag, "_word_count"}, {28'd0, word_count}, 32'd0);
  endtask

  initial begin
    logic [31:0] basic[$];
    logic [31:0] prog[$];
    logic [31:0] ovf[$];
    logic [31:0] one[$];
    basic = '{32'h00100093, END_W};
    ovf   = '{32'h1, 32'h2, 32'h3, 32'h4};
    one   = '{END_W};

    // Reset
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    // Basic load, then the same stream with 3-cycle gaps.
    run_load(basic, 0, 1'b0, 1'b0);
    run_load(basic, 3, 1'b0, 1'b0);

    // Overflow: four non-terminator words fill memory.
    run_load(ovf, 0, 1'b0, 1'b0);

    // Reset in the middle of word 0.
    pulse_start();
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    #2 reset = 1'b1;
    #1 check_reset_values("midreset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_load(basic, 0, 1'b0, 1'b0);

    // start ignored mid-RECV, then reload a one-word program after DONE.
    run_load(basic, 1, 1'b0, 1'b1);
    run_load(one, 0, 1'b0, 1'b0);

    // Wrong checksum is rejected.
    if (CHK_EN) run_load(basic, 0, 1'b1, 1'b0);

    // Random programs: terminator at a random position (past the end means overflow).
    for (int t = 0; t < 20; t++) begin
      int p;
      prog.delete();
      p = $urandom_range(0, 5);
      for (int i = 0; i < 6; i++) begin
        logic [31:0] w;
        w = $urandom;
        if (w == END_W) w = w ^ 32'h1;
        prog.push_back(i == p ? END_W : w);
      end
      run_load(prog, $urandom_range(0, 2), CHK_EN && ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
